// File: rtl/reg_file_mp.sv
// Multi-ported register file with registered reads, write bypass and a
// sequential flush engine that zeroes one entry per cycle.
module reg_file_mp #(
   parameter  int NUM_REGS = 128,
   parameter  int DATA_WD  = 128,
   parameter  int NUM_RD   = 3,
   parameter  int NUM_WR   = 2,
   parameter  int BYPASS   = 1,
   localparam int RADDR_WD = $clog2(NUM_REGS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_RD-1:0][RADDR_WD-1:0]   rd_addr,
   output logic [NUM_RD-1:0][DATA_WD-1:0]    rd_data,
   input  logic [NUM_WR-1:0]                 wr_en,
   input  logic [NUM_WR-1:0][RADDR_WD-1:0]   wr_addr,
   input  logic [NUM_WR-1:0][DATA_WD-1:0]    wr_data,
   input  logic                              clr_req,
   output logic                              busy,
   output logic                              wr_drop
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [RADDR_WD-1:0] LAST = RADDR_WD'(NUM_REGS - 1);

   state_t                           state, state_nxt;
   logic [RADDR_WD-1:0]              clr_ptr, clr_ptr_nxt;
   logic [DATA_WD-1:0]               mem [NUM_REGS];
   logic [NUM_RD-1:0][DATA_WD-1:0]   rd_nxt;

   assign busy = (state == CLEAR);

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      unique case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt   = CLEAR;
               clr_ptr_nxt = '0;
            end
         end
         CLEAR: begin
            clr_ptr_nxt = clr_ptr + RADDR_WD'(1);
            if (clr_ptr == LAST) state_nxt = IDLE;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Later write ports override earlier ones when addresses collide.
   always_comb begin
      rd_nxt = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_nxt[i] = mem[rd_addr[i]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && wr_addr[j] == rd_addr[i])
                  rd_nxt[i] = wr_data[j];
            end
         end
         if (busy) rd_nxt[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         rd_data <= '0;
         wr_drop <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
         rd_data <= rd_nxt;
         wr_drop <= busy && (|wr_en);
      end
   end

   // Array has no reset; the flush engine zeroes it after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy) begin
            mem[clr_ptr] <= '0;
         end else begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j]) mem[wr_addr[j]] <= wr_data[j];
            end
         end
      end
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 128, number of entries (power of 2, >=4).
REQ-002 SHALL have parameter DATA_WD, default 128, entry width in bits.
REQ-003 SHALL have parameter NUM_RD, default 3, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports; port 0 = even pipe, port 1 = odd pipe.
REQ-005 SHALL have parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-006 SHALL have derived parameter RADDR_WD = $clog2(NUM_REGS).
REQ-007 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clk.
REQ-009 SHALL have port rd_addr, input, [NUM_RD][RADDR_WD], read addresses.
REQ-010 SHALL have port rd_data, output, [NUM_RD][DATA_WD], registered read data.
REQ-011 SHALL have port wr_en, input, [NUM_WR], write enables.
REQ-012 SHALL have port wr_addr, input, [NUM_WR][RADDR_WD], write addresses.
REQ-013 SHALL have port wr_data, input, [NUM_WR][DATA_WD], write data.
REQ-014 SHALL have port clr_req, input, 1, single-cycle request to flush the whole array to zero.
REQ-015 SHALL have port busy, output, 1, high while a clear sequence is running.
REQ-016 SHALL have port wr_drop, output, 1, pulses for one cycle when any wr_en is discarded during busy.

Function
REQ-017 SHALL give every read port independent access with 1-cycle latency: rd_data[i] at edge N+1 reflects rd_addr[i] sampled at edge N.
REQ-018 SHALL, when BYPASS=1, return wr_data[j] on rd_data[i] if wr_en[j] is set and wr_addr[j]==rd_addr[i] in the same cycle.
REQ-019 SHALL, when BYPASS=0, return the pre-write array content under the same condition.
REQ-020 SHALL commit every enabled write at the clock edge.
REQ-021 SHALL, when several write ports target one address, commit and forward the data of the highest-index enabled port only.
REQ-022 SHALL implement FSM states IDLE and CLEAR with a RADDR_WD-bit clear pointer clr_ptr.
REQ-023 SHALL, in IDLE with clr_req=1, move to CLEAR with clr_ptr=0 and busy=1 at the next edge.
REQ-024 SHALL, in CLEAR, zero entry clr_ptr each cycle and then increment clr_ptr.
REQ-025 SHALL, in CLEAR with clr_ptr==NUM_REGS-1, clear that entry and return to IDLE, so busy=0 at the following edge; a clear lasts exactly NUM_REGS cycles.
REQ-026 SHALL ignore clr_req while in CLEAR; the pointer does not restart.
REQ-027 SHALL, while busy, discard all wr_en, drive all rd_data to 0, and set wr_drop=1 in the next cycle if any wr_en was high.
REQ-028 SHALL, on clr_req and wr_en in the same IDLE cycle, commit the write first; the clear then overwrites it with 0.
REQ-029 SHALL treat rd_addr values as always in range; no out-of-range handling is required.

Reset
REQ-030 SHALL, on reset, drive rd_data=0 and wr_drop=0, set state=CLEAR, clr_ptr=0 and busy=1; the array is zeroed by the FSM, not in one cycle.
REQ-031 SHALL restart a clear at clr_ptr=0 when reset is asserted mid-clear.
REQ-032 SHALL give reset priority over clr_req, wr_en and the read path.

Verification
REQ-033 SHALL check reset deassert: busy stays high for exactly 128 cycles, then every address reads 0x0 on all 3 ports.
REQ-034 SHALL check a write-then-read: write 0xDEAD_BEEF to reg 5 via port 0, then read reg 5 on all ports next cycle; expect 0xDEAD_BEEF one cycle later.
REQ-035 SHALL check bypass: in one cycle, write 0x1234 to reg 9 and read reg 9; with BYPASS=1 expect 0x1234, with BYPASS=0 expect the old value 0x0.
REQ-036 SHALL check write conflict: port 0 writes 0xAAAA and port 1 writes 0x5555 to reg 20 in the same cycle; reg 20 reads 0x5555.
REQ-037 SHALL check a flush: fill regs 0-127 with nonzero data, pulse clr_req, and write reg 3 during busy; expect wr_drop pulse, busy for 128 cycles, and all regs 0 afterward.
REQ-038 SHALL check reset mid-clear: assert reset at clr_ptr=60; busy then lasts 128 further cycles.
